// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | riscv_muldiv_pkg : op encodings, FSM states and signedness helpers        |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package riscv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_div_step.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | riscv_div_step : one combinational restoring-division step                |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_bits;

  assign shifted = {rem_i, bit_i};
  assign diff    = {1'b0, shifted} - {2'b00, div_i};
  assign q_o     = ~diff[XLEN+1];
  // rem_i < div_i keeps both candidates below div_i, so the top bits are always zero
  assign rem_o       = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign unused_bits = diff[XLEN] ^ shifted[XLEN];

endmodule
`default_nettype wire

// File: rtl/riscv_muldiv.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | riscv_muldiv : iterative RV32M/RV64M multiply/divide unit with issue tag  |
// | Option: RISCV_MULDIV_FAST_MUL_EN selects single-cycle multiplies          |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int               CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d, tag_out_q, tag_out_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              valid_q, valid_d;

  logic              sign_a, sign_b, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              special;
  logic [XLEN-1:0]   special_res;

  assign sign_a = is_signed_a(op_i) & a_i[XLEN-1];
  assign sign_b = is_signed_b(op_i) & b_i[XLEN-1];
  assign mag_a  = sign_a ? -a_i : a_i;
  assign mag_b  = sign_b ? -b_i : b_i;
  assign neg_in = (op_i == OP_REM) ? sign_a : (sign_a ^ sign_b);

`ifdef RISCV_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_prod = neg_in ? -fast_mag : fast_mag;
`endif

  // Results known at accept bypass the iterative datapath entirely
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div(op_i) && (b_i == '0)) begin
      special     = 1'b1;
      special_res = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == MOST_NEG) && (b_i == '1)) begin
      special     = 1'b1;
      special_res = (op_i == OP_DIV) ? a_i : '0;
    end
`ifdef RISCV_MULDIV_FAST_MUL_EN
    else if (!is_div(op_i)) begin
      special     = 1'b1;
      special_res = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] acc_step;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q & {XLEN{acc_q[0]}}};

  riscv_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .div_i (opnd_q),
    .bit_i (acc_q[XLEN-1]),
    .rem_o (div_rem),
    .q_o   (div_q)
  );

  assign acc_step = is_div(op_q) ? {div_rem, acc_q[XLEN-2:0], div_q}
                                 : {mul_sum, acc_q[XLEN-1:1]};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    final_res = rem_fix;
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    res_d     = res_q;
    tag_out_d = tag_out_q;
    valid_d   = valid_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_d  = op_i;
            tag_d = tag_i;
            neg_d = neg_in;
            cnt_d = CNT_INIT;
            if (is_div(op_i)) begin
              opnd_d = mag_b;
              acc_d  = {{XLEN{1'b0}}, mag_a};
            end else begin
              opnd_d = mag_a;
              acc_d  = {{XLEN{1'b0}}, mag_b};
            end
            if (special) begin
              state_d   = ST_DONE;
              valid_d   = 1'b1;
              res_d     = special_res;
              tag_out_d = tag_i;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            res_d     = final_res;
            tag_out_d = tag_q;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      tag_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      tag_out_q <= tag_out_d;
      valid_q   <= valid_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE) && !flush_i;
  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign tag_o    = tag_out_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_riscv_muldiv : scoreboard bench with arithmetic reference model        |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_riscv_muldiv;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
`ifdef RISCV_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [2:0]       op_i = '0;
  logic [XLEN-1:0]  a_i = '0;
  logic [XLEN-1:0]  b_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             flush_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  riscv_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rdy_mode = 0;
  logic [3:0] tg_ctr = 4'd1;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  // Reference model: RISC-V M-extension semantics via wide plain arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    xa = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    case (op)
      3'd0:             return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  // Downstream ready: 0 random, 1 held low, 2 held high
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       ready_i = ($urandom_range(0, 2) != 0);
      1:       ready_i = 1'b0;
      default: ready_i = 1'b1;
    endcase
  end

  // Monitor: latency on each valid rise, data/tag on each handshake
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: actual valid_o=1 required 0 (result %h)", result_o);
        end else begin
          check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
        end
      end
      if (valid_o && ready_i && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result_o, e.res);
        check("tag", 32'(tag_o), 32'(e.tag));
      end
    end
    prev_valid = rst_ni ? valid_o : 1'b0;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] e, output logic [3:0] t);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    t = tg_ctr;
    tg_ctr++;
    if (!ready_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: actual ready_o=0 required 1");
      return;
    end
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    tag_i   = t;
    if (push) exp_q.push_back('{e, t, cyc, lat_of(op, a, b)});
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    tag_i   = 4'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  d_op  [9] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1, 3'd2, 3'd0};
  logic [31:0] d_a   [9] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_1234, 32'h0000_1234,
                             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_b   [9] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234,
                             32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001};

  initial begin
    logic [3:0]  t, bp_tag;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          w;
    bit          saw_valid;

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_result_o", result_o, 32'd0);
    check("rst_tag_o", 32'(tag_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);

    for (int i = 0; i < 9; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, d_exp[i], t);
    drain();

    // Backpressure: hold the result in DONE for five cycles
    rdy_mode = 1;
    issue(3'd4, 32'd100, 32'd7, 1'b1, 32'd14, bp_tag);
    w = 0;
    while (!valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_rise", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result_hold", result_o, 32'd14);
      check("bp_tag_hold", 32'(tag_o), 32'(bp_tag));
      check("bp_ready_o_low", 32'(ready_o), 32'd0);
      check("bp_busy_o_high", 32'(busy_o), 32'd1);
    end
    rdy_mode = 2;
    w = 0;
    while (valid_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_ready_o_after", 32'(ready_o), 32'd1);
    check("bp_busy_o_after", 32'(busy_o), 32'd0);

    // Flush in the middle of an iterative divide
    issue(3'd4, 32'h1234_5678, 32'd3, 1'b0, 32'd0, t);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy_o", 32'(busy_o), 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
    end
    check("flush_no_valid", 32'(saw_valid), 32'd0);

    // Flush and request together: nothing is accepted
    valid_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 3'd6;
    a_i     = 32'd9;
    b_i     = 32'd0;
    #1;
    check("flushreq_ready_o", 32'(ready_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flushreq_busy_o", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("flushreq_valid_o", 32'(valid_o), 32'd0);

    // Asynchronous reset mid-operation
    issue(3'd5, 32'hDEAD_BEEF, 32'd5, 1'b0, 32'd0, t);
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("arst_valid_o", 32'(valid_o), 32'd0);
    check("arst_result_o", result_o, 32'd0);
    check("arst_tag_o", 32'(tag_o), 32'd0);
    check("arst_busy_o", 32'(busy_o), 32'd0);
    check("arst_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;

    // Randomized traffic against the reference model
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_opnd();
      rb  = rand_opnd();
      issue(rop, ra, rb, 1'b1, model(rop, ra, rb), t);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M/RV64M multiply/divide unit, parametrised in data width. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over a valid/ready handshake. It sits beside the single-cycle ALU in the execute stage and holds one operation in flight. Each result returns with the issuer's tag so the dual-issue pipeline can route writeback.

## Interface
- XLEN, 32: operand/result width; even, >= 8
- TAG_W, 4: width of the issue tag carried through the unit
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept; high only in IDLE with flush_i low
- op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a_i  in  XLEN  rs1 operand
- b_i  in  XLEN  rs2 operand
- tag_i  in  TAG_W  issue tag
- flush_i  in  1  kill any in-flight operation
- valid_o  out  1  result available
- ready_i  in  1  downstream accepts the result
- result_o  out  XLEN  result
- tag_o  out  TAG_W  tag of the result
- busy_o  out  1  state != IDLE

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset puts it in IDLE with valid_o=0, result_o=0, tag_o=0, busy_o=0 and ready_o=1.
- Accept happens when valid_i && ready_o. At accept the unit registers op, tag, operand magnitudes, result sign and count=XLEN.
- Result sign rules:
  - MULH: sign(a)^sign(b).
  - MULHSU: sign(a) only.
  - MULHU/DIVU/REMU: unsigned.
  - DIV: sign(a)^sign(b).
  - REM: sign(a).
  - MUL: result is the low word, so signedness is irrelevant.
- Multiply is radix-2 shift-add over magnitudes into a 2*XLEN accumulator, one bit per BUSY cycle. The product is negated if the sign flag is set. MUL returns bits [XLEN-1:0]; the MULH variants return [2*XLEN-1:XLEN].
- Divide is restoring, one quotient bit per BUSY cycle. Quotient and remainder are corrected by sign after the last step.
- Special cases are resolved at accept, go IDLE->DONE directly, and skip BUSY:
  - divide by zero: DIV/DIVU give all-ones; REM/REMU give a_i.
  - signed overflow (a_i = most-negative, b_i = -1): DIV gives a_i; REM gives 0.
- BUSY decrements count each cycle and moves to DONE when count reaches 0, with result_o/tag_o registered.
- DONE holds valid_o=1 with result_o and tag_o stable until ready_i. On handshake it returns to IDLE. ready_o stays low in DONE: there is no back-to-back issue.
- flush_i in any state sends the FSM to IDLE on the next edge and drops valid_o. If flush_i and valid_i are high together, flush wins and nothing is accepted.
- Reset asserted mid-operation clears the unit immediately. No result is produced.

## Timing
- Iterative path: accept at edge T, XLEN BUSY cycles, valid_o high from edge T+XLEN+1 (33 cycles for XLEN=32).
- Special-case path: valid_o high from edge T+1.
- ready_o and busy_o are combinational from state and flush_i. All other outputs are registered.
- Operand inputs are sampled only at accept and may change afterwards.

## Configuration
- RISCV_MULDIV_FAST_MUL_EN:
  - Defined: all four multiply ops compute the full 2*XLEN product combinationally at accept and go IDLE->DONE, so valid_o rises at T+1.
  - Undefined: multiplies use the iterative path with T+XLEN+1 latency.
- Division is always iterative.

## Structure
- Package riscv_muldiv_pkg holds the op_i encoding constants, the IDLE/BUSY/DONE state encoding, and the helpers is_div(op) and is_signed_a(op)/is_signed_b(op).
- Sub-module riscv_div_step is a combinational single restoring-division step: partial remainder, divisor and dividend bit in; next remainder and quotient bit out. It is instantiated once in the datapath.

## Test plan
- DIV a=0xFFFFFFF9 (-7), b=2: result 0xFFFFFFFD with valid_o exactly 33 cycles after accept. REM on the same operands: 0xFFFFFFFF.
- DIVU a=0x00001234, b=0: 0xFFFFFFFF. REMU: 0x00001234. valid_o 1 cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF: 0x80000000. REM: 0x00000000. 1-cycle latency.
- Multiplies:
  - MULH 0x80000000 × 0x80000000: 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF: 0xFFFFFFFF.
  - MUL on the same operands: 0x00000001.
  - Latency is 1 with RISCV_MULDIV_FAST_MUL_EN, 33 without.
- Backpressure: hold ready_i=0 for 5 cycles in DONE. result_o/tag_o stay stable, ready_o=0 and busy_o=1. After ready_i=1 the unit is in IDLE with ready_o=1 next cycle.
- Flush and reset:
  - flush_i at BUSY cycle 10: busy_o=0 next cycle and no valid_o ever appears.
  - flush_i together with valid_i: no accept.
  - rst_ni low mid-BUSY: all outputs reset immediately.
